// File: rtl/vx_tex_sat_seq_pkg.sv
// Shared types and helpers for the texture saturation sequencer.
package vx_tex_sat_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // A single-beat configuration still needs a one-bit counter.
  function automatic int beat_cnt_w(input int num_beats);
    return (num_beats > 1) ? $clog2(num_beats) : 1;
  endfunction

endpackage

// File: rtl/vx_tex_sat_seq_sat.sv
// Clamps one signed IN_W-bit channel into the unsigned OUT_W-bit range.
module vx_tex_sat #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 8,
  parameter int MODEL = 1
) (
  input  logic [IN_W-1:0]  data_in,
  output logic [OUT_W-1:0] data_out
);

  localparam logic [IN_W-1:0] MAX_V = IN_W'((1 << OUT_W) - 1);

  logic over;

  // Negative inputs are caught first, so an unsigned compare is safe here.
  generate
    if (MODEL == 1) begin : g_cmp
      assign over = (data_in > MAX_V);
    end else begin : g_bits
      assign over = |data_in[IN_W-2:OUT_W];
    end
  endgenerate

  always_comb begin
    if (data_in[IN_W-1]) begin
      data_out = '0;
    end else if (over) begin
      data_out = '1;
    end else begin
      data_out = data_in[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/vx_tex_sat_seq.sv
// Multi-beat sequencer feeding a request through ELEMS_PER_CYCLE shared
// saturation units and returning the assembled result as one tagged response.
module vx_tex_sat_seq
  import vx_tex_sat_seq_pkg::*;
#(
  parameter int NUM_ELEMS       = 16,
  parameter int ELEMS_PER_CYCLE = 4,
  parameter int IN_W            = 10,
  parameter int OUT_W           = 8,
  parameter int TAG_W           = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       req_valid,
  input  logic [NUM_ELEMS*IN_W-1:0]  req_data,
  input  logic [TAG_W-1:0]           req_tag,
  output logic                       req_ready,
  output logic                       rsp_valid,
  output logic [NUM_ELEMS*OUT_W-1:0] rsp_data,
  output logic [TAG_W-1:0]           rsp_tag,
  input  logic                       rsp_ready,
  output logic                       busy
);

  localparam int NUM_BEATS   = NUM_ELEMS / ELEMS_PER_CYCLE;
  localparam int BEAT_W      = beat_cnt_w(NUM_BEATS);
  localparam int SLICE_IN_W  = ELEMS_PER_CYCLE * IN_W;
  localparam int SLICE_OUT_W = ELEMS_PER_CYCLE * OUT_W;

  generate
    if (((NUM_ELEMS % ELEMS_PER_CYCLE) != 0) || ((OUT_W + 1) >= IN_W)) begin : g_param_err
      $error("vx_tex_sat_seq: illegal NUM_ELEMS/ELEMS_PER_CYCLE/IN_W/OUT_W combination");
    end
  endgenerate

  state_e                     state_q, state_d;
  logic [BEAT_W-1:0]          beat_q, beat_d;
  logic [NUM_ELEMS*IN_W-1:0]  data_q, data_d;
  logic [TAG_W-1:0]           tag_q, tag_d;
  logic [NUM_ELEMS*OUT_W-1:0] res_q, res_d;
  logic [SLICE_IN_W-1:0]      slice_in;
  logic [SLICE_OUT_W-1:0]     slice_out;
  logic                       accept;

  always_comb begin
    slice_in = data_q[SLICE_IN_W-1:0];
    for (int b = 0; b < NUM_BEATS; b++) begin
      if (beat_q == BEAT_W'(b)) begin
        slice_in = data_q[b*SLICE_IN_W +: SLICE_IN_W];
      end
    end
  end

  for (genvar e = 0; e < ELEMS_PER_CYCLE; e++) begin : g_sat
    vx_tex_sat #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .MODEL (1)
    ) u_sat (
      .data_in  (slice_in[e*IN_W +: IN_W]),
      .data_out (slice_out[e*OUT_W +: OUT_W])
    );
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    data_d    = data_q;
    tag_d     = tag_q;
    res_d     = res_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid;
      end
      BUSY: begin
        for (int b = 0; b < NUM_BEATS; b++) begin
          if (beat_q == BEAT_W'(b)) begin
            res_d[b*SLICE_OUT_W +: SLICE_OUT_W] = slice_out;
          end
        end
        if (beat_q == BEAT_W'(NUM_BEATS - 1)) begin
          state_d = DONE;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        req_ready = rsp_ready;
        accept    = req_valid && rsp_ready;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Retiring a response and taking the next request share one edge.
    if (accept) begin
      data_d  = req_data;
      tag_d   = req_tag;
      beat_d  = '0;
      state_d = BUSY;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      data_q  <= '0;
      tag_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
    end
  end

  assign rsp_data = res_q;
  assign rsp_tag  = tag_q;
  assign busy     = (state_q != IDLE);

endmodule
